// File: rtl/dff.sv
// Parameterizable-width D flip-flop with a configurable number of register stages.
// Synchronous active-high reset loads RESET_VALUE into every stage; power-up state matches it.
module dff #(
    parameter int                WIDTH       = 1,
    parameter int                DEPTH       = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    output logic [WIDTH-1:0] q,
    input  logic             rest
);

    // Stages start at RESET_VALUE so q is defined before the first clock edge.
    logic [WIDTH-1:0] s [DEPTH] = '{default: RESET_VALUE};

    // Only an explicit 1 resets: an X or floating reset falls through to normal capture.
    always_ff @(posedge clk) begin
        if (rest == 1'b1) begin
            for (int i = 0; i < DEPTH; i++) begin
                s[i] <= RESET_VALUE;
            end
        end else begin
            s[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                s[i] <= s[i-1];
            end
        end
    end

    assign q = s[DEPTH-1];

endmodule

// File: tb/tb_dff.sv
// Directed bench for dff: a default 1-bit/1-stage instance and an 8-bit/3-stage instance.
module tb_dff;

    logic       clk = 1'b0;
    logic       d1;
    logic       rest1;
    logic       q1;
    logic [7:0] d2;
    logic       rest2;
    logic [7:0] q2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dff u_dff1 (
        .d    (d1),
        .clk  (clk),
        .q    (q1),
        .rest (rest1)
    );

    dff #(
        .WIDTH       (8),
        .DEPTH       (3),
        .RESET_VALUE (8'hA5)
    ) u_dff3 (
        .d    (d2),
        .clk  (clk),
        .q    (q2),
        .rest (rest2)
    );

    task automatic test_reset();
        // Power-up, before the first rising edge.
        #1;
        total++;
        if (q1 !== 1'b0) begin
            bad++;
            $display("FAIL powerup_q1 got=%b want=%b", q1, 1'b0);
        end
        total++;
        if (q2 !== 8'hA5) begin
            bad++;
            $display("FAIL powerup_q2 got=%h want=%h", q2, 8'hA5);
        end
    endtask

    task automatic test_basic();
        logic vec [5];
        vec = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        // d1 = 0 is already applied from t0; first check follows the edge at t=5.
        @(posedge clk); #1;
        total++;
        if (q1 !== vec[0]) begin
            bad++;
            $display("FAIL basic_0 got=%b want=%b", q1, vec[0]);
        end
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            d1 = vec[i];
            #1;
            total++;
            if (q1 !== vec[i-1]) begin
                bad++;
                $display("FAIL basic_nocomb_%0d got=%b want=%b", i, q1, vec[i-1]);
            end
            @(posedge clk); #1;
            total++;
            if (q1 !== vec[i]) begin
                bad++;
                $display("FAIL basic_%0d got=%b want=%b", i, q1, vec[i]);
            end
        end
    endtask

    task automatic test_sync_reset();
        @(negedge clk); d1 = 1'b1; rest1 = 1'b0;
        @(posedge clk); #1;
        total++;
        if (q1 !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre got=%b want=%b", q1, 1'b1);
        end
        @(negedge clk); rest1 = 1'b1; d1 = 1'b1;
        @(posedge clk); #1;
        total++;
        if (q1 !== 1'b0) begin
            bad++;
            $display("FAIL rst_apply got=%b want=%b", q1, 1'b0);
        end
        @(negedge clk); rest1 = 1'b0; d1 = 1'b1;
        @(posedge clk); #1;
        total++;
        if (q1 !== 1'b1) begin
            bad++;
            $display("FAIL rst_release got=%b want=%b", q1, 1'b1);
        end
    endtask

    task automatic test_rest_glitch();
        // Reset pulse entirely between edges must not touch q.
        @(negedge clk); d1 = 1'b0;
        #1 rest1 = 1'b1;
        #2;
        total++;
        if (q1 !== 1'b1) begin
            bad++;
            $display("FAIL glitch_mid got=%b want=%b", q1, 1'b1);
        end
        rest1 = 1'b0;
        @(posedge clk); #1;
        total++;
        if (q1 !== 1'b0) begin
            bad++;
            $display("FAIL glitch_after got=%b want=%b", q1, 1'b0);
        end
    endtask

    task automatic test_pipeline();
        logic [7:0] din  [12];
        logic       rin  [12];
        logic [7:0] qexp [12];
        // Reset, fill 11/22/33, mid-stream reset, refill, held reset, refill.
        din  = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hEE, 8'hFF};
        rin  = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
        qexp = '{8'hA5, 8'hA5, 8'hA5, 8'h11, 8'h22, 8'h33, 8'hA5, 8'hA5, 8'hA5, 8'h77, 8'hA5, 8'hA5};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            d2    = din[i];
            rest2 = rin[i];
            @(posedge clk); #1;
            total++;
            if (q2 !== qexp[i]) begin
                bad++;
                $display("FAIL pipe_%0d got=%h want=%h", i, q2, qexp[i]);
            end
        end
        // Release after a multi-cycle reset: A5 A5 then the new data.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rest2 = 1'b0;
            d2    = 8'hC0 + 8'(i);
            @(posedge clk); #1;
            total++;
            if (q2 !== ((i < 2) ? 8'hA5 : 8'hC0)) begin
                bad++;
                $display("FAIL pipe_refill_%0d got=%h want=%h", i, q2, (i < 2) ? 8'hA5 : 8'hC0);
            end
        end
    endtask

    task automatic test_unconnected_rest();
        logic vec [5];
        vec = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rest1 = 1'bz;
            d1    = vec[i];
            @(posedge clk); #1;
            total++;
            if (q1 !== vec[i]) begin
                bad++;
                $display("FAIL float_rest_%0d got=%b want=%b", i, q1, vec[i]);
            end
        end
    endtask

    initial begin
        d1    = 1'b0;
        rest1 = 1'b0;
        d2    = 8'h00;
        rest2 = 1'b0;
        test_reset();
        test_basic();
        test_sync_reset();
        test_rest_glitch();
        test_pipeline();
        test_unconnected_rest();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dff.md
Name: dff

Overview:
- Positive-edge D flip-flop: a parameterizable-width register with an optional pipeline depth.
- It is a basic storage/delay primitive used wherever a signal needs registering on the system clock.
- It has a synchronous, active-high reset that forces the register contents to a programmable value.
- With default parameters it is a single-bit, single-stage DFF.

Parameters:
- WIDTH, 1, bit width of d and q.
- DEPTH, 1, number of register stages between d and q (must be >= 1).
- RESET_VALUE, '0 (all zeros, WIDTH bits), value loaded into every stage on reset and at power-up.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rest  input  1  reset, synchronous, active-high.
- d  input  WIDTH  data input.
- q  output  WIDTH  registered data output, driven directly from the last stage.
- Declaration order is d, clk, q, rest, so positional 3-port hookups (d, clk, q) remain valid.

Behaviour:
- One clock; reset is synchronous and active-high.
- Storage is DEPTH stages s[0..DEPTH-1]; q = s[DEPTH-1].
- Rising edge of clk with rest==1: every stage <= RESET_VALUE, so q = RESET_VALUE after that edge.
- Rising edge of clk with rest!=1 (0, X or Z):
  - s[0] <= d;
  - s[i] <= s[i-1] for i >= 1.
- An unconnected reset therefore never resets the block.
- Latency: d sampled at edge N appears on q immediately after edge N+DEPTH-1. For DEPTH=1, q follows d one edge later.
- No asynchronous path:
  - rest asserting or deasserting between edges has no effect until the next rising edge;
  - q never changes except at a rising clk edge.
- Power-up/initial state: all stages initialised to RESET_VALUE, so q = RESET_VALUE before the first edge.
- d changing exactly between edges: the value present at the rising edge is captured; glitches between edges are ignored.
- Reset mid-stream (DEPTH>1): all in-flight data is discarded in the same edge. Capture resumes from d on the first edge with rest low.
- rest held high for multiple cycles: q stays at RESET_VALUE regardless of d.
- Pure register block: no combinational path from d or rest to q.

Test Plan:
- DEPTH=1, WIDTH=1, clk period 10 (rising edges at 5, 15, 25, 35, 45), rest=0. Drive d=0 at t0, 1@10, 0@20, 1@30, 0@40 -> q=0 after 5, 1 after 15, 0 after 25, 1 after 35, 0 after 45.
- Power-up with no edges yet, RESET_VALUE=0 -> q=0 at t=1.
- rest=1 for one edge with d=1, q previously 1 -> q=RESET_VALUE (0) after that edge. With rest then 0 and d=1, q=1 after the following edge.
- rest pulsed high between edges and low again before the next rising edge -> q unchanged.
- WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5:
  - after reset, q=A5;
  - drive d=11, 22, 33 on consecutive edges -> q shows 11, 22, 33 starting 2 edges after d=11 was sampled.
  - Assert rest for one edge mid-stream -> q=A5 on the very next edge, and the pipeline refills afterwards.
- rest left unconnected (Z), d toggling -> q tracks d with 1-edge latency and never resets.
